shift_rows_fifo: RTL

SHIFT_ROWS_FIFO -- requirements
Module: shift_rows_fifo

---
 rtl/shift_rows_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_rows_fifo.sv
// Rijndael ShiftRows/InvShiftRows on NB-column states, feeding a DEPTH-entry output FIFO.
// Optional row-parity fault detection is enabled by defining SHIFTROWS_PARITY_EN.
module shift_rows_fifo #(
    parameter int unsigned NB    = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic            in_inv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_data,
    output logic            err
);

    localparam int unsigned W  = 32 * NB;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Byte k lives at row k%4, column k/4, with byte 0 in the MSBs.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] o;
        int unsigned  off;
        int unsigned  src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            off = (NB == 8 && r >= 2) ? r + 1 : r;
            for (int unsigned c = 0; c < NB; c++) begin
                src = inv ? (c + NB - off) % NB : (c + off) % NB;
                o[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [W-1:0]  perm;
    logic          push;
    logic          pop;
    logic          bypass;

    always_comb begin
        push    = in_valid & in_ready_q;
        pop     = out_valid_q & out_ready;
        perm    = shift_rows(in_data, in_inv);
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        // The word being written becomes the head when nothing older remains.
        bypass  = push && (rptr_d == wptr_q);
        out_data_d = out_data_q;
        if (count_d != '0) begin
            out_data_d = bypass ? perm : mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= perm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d < CW'(DEPTH));
            out_valid_q <= (count_d != '0);
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SHIFTROWS_PARITY_EN
    // Row parity is invariant under row rotation, so input parity checks the output.
    function automatic logic [3:0] row_par(input logic [W-1:0] d);
        logic [3:0] p;
        p = '0;
        for (int unsigned k = 0; k < 4 * NB; k++) begin
            p[k%4] = p[k%4] ^ (^d[W-1-8*k -: 8]);
        end
        return p;
    endfunction

    logic [3:0] par_mem_q [DEPTH];
    logic [3:0] head_par_q, head_par_d;
    logic [3:0] in_par;
    logic       err_q;

    always_comb begin
        in_par     = row_par(in_data);
        head_par_d = head_par_q;
        if (count_d != '0) begin
            head_par_d = bypass ? in_par : par_mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem_q[wptr_q] <= in_par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_par_q <= '0;
            err_q      <= 1'b0;
        end else begin
            head_par_q <= head_par_d;
            if (out_valid_q && (row_par(out_data_q) != head_par_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
